asl_slow_issue_bridge: RTL and testbench
========================================

Name: asl_slow_issue_bridge

Overview:
Rate-adapting issue stage that sits directly downstream of the divide-by-16 clock divider in the NICE accelerator path. It accepts words from the NICE-side producer at full clk_in rate and buffers them in a small FIFO. On each rising edge of the divided clock level it releases exactly one word to the PE array, holding that word stable for a full slow period. Everything runs in the single clk_in domain; the divided clock is treated as a data-level input and never used as a clock.

Parameters:
DW, 32, data word width
DEPTH, 4, FIFO depth in words; must be a power of 2 and at least 2
AW, 2, pointer width, log2(DEPTH)

Ports:
clk_in  input  1  system clock
rst_n  input  1  asynchronous active-low reset
div_clk  input  1  divided clock level from the divider, synchronous to clk_in
flush  input  1  synchronous clear of FIFO and output stage
in_valid  input  1  producer word valid
in_ready  output  1  FIFO can accept a word
in_data  input  DW  producer word
out_data  output  DW  word presented to PE array, stable between ticks
out_valid  output  1  out_data holds a word issued at the latest tick
slow_tick  output  1  one-cycle pulse per div_clk rising edge
fifo_cnt  output  AW+1  words currently buffered (0..DEPTH)
issue_cnt  output  16  words issued since reset or flush, wraps at 2^16

Behaviour:
- Clock and reset: one clock, clk_in. rst_n is asynchronous and active-low.
- Reset values: every register is 0. This covers div_q, pointers, count, out_data, out_valid, slow_tick and issue_cnt. in_ready is therefore 1 after reset.
- Edge detect:
  - div_q <= div_clk every cycle.
  - rise = div_clk & ~div_q (combinational).
  - The first div_clk high after reset counts as a rise.
- Push:
  - in_ready = (count != DEPTH) & ~flush, combinational.
  - A push occurs when in_valid & in_ready. It writes mem[wr_ptr], then wr_ptr++ with wrap modulo DEPTH.
- Tick and pop, on a cycle with rise=1:
  - slow_tick <= 1, registered, so the pulse appears in the cycle after rise.
  - If count > 0: out_data <= mem[rd_ptr], out_valid <= 1, rd_ptr++ (wrap), issue_cnt++ (wrap).
  - If count = 0: out_valid <= 0 and out_data holds its old value. This is an underrun.
- Cycles with rise=0: slow_tick <= 0; out_data and out_valid hold.
- Latency:
  - A word pushed into an empty FIFO at cycle t is issued at the first rise at cycle >= t+1.
  - A push and a rise in the same cycle on an empty FIFO do not issue that word.
  - out_data/out_valid update in the same cycle slow_tick goes high.
- Simultaneous push and pop:
  - count is unchanged and both pointers advance.
  - At full, in_ready is already 0, so no push occurs even though a pop frees a slot. This is a deliberate conservative rule.
- Empty/full:
  - Push never overflows, because in_ready gates it.
  - Pop never occurs at count = 0.
  - fifo_cnt = count, registered.
- Flush:
  - Priority over push and pop.
  - Clears pointers, count, out_valid and issue_cnt. out_data holds.
  - Edge detection and slow_tick continue normally during flush.
- Reset mid-operation: all state clears immediately. Buffered words are lost.
- Rate: with the divider toggling every 8 clk_in cycles, a rise occurs every 16 cycles. Sustained throughput is 1 word per 16 cycles, and the producer is back-pressured once DEPTH words are buffered.

Decomposition:
- Shared package holds:
  - ASL_DW = 32
  - ASL_BRIDGE_DEPTH = 4
  - ASL_DIV_HALF_PERIOD = 8
  - ASL_ISSUE_CNT_W = 16
- One natural sub-module, asl_sync_fifo, which owns storage, pointers, count, push/pop and full/empty.
- The top level keeps the edge detector, output register, tick and issue counter.

Test Plan:
- Reset release, div_clk toggling every 8 cycles, no input -> in_ready=1, out_valid=0, slow_tick pulses exactly every 16 cycles, issue_cnt=0.
- Push 0xA5A5_0001 at cycle 3, rise at cycle 8 -> at cycle 9: out_data=0xA5A5_0001, out_valid=1, slow_tick=1, fifo_cnt=0, issue_cnt=1; out_data is unchanged through cycle 24.
- Burst of 6 words 0x10..0x15 with in_valid held high, no rise in the window -> 4 accepted, in_ready=0 at fifo_cnt=4. After the next rise, 0x10 is issued and in_ready returns to 1 one cycle later. Words issue in order, one per 16 cycles.
- FIFO holding 1 word, push and rise in the same cycle -> the old word is issued, fifo_cnt stays 1, and the new word is issued at the following rise.
- Underrun: FIFO empty at a rise with out_valid=1 -> out_valid=0, out_data holds the previous value, issue_cnt is unchanged.
- flush asserted with fifo_cnt=3 and issue_cnt=5 -> next cycle fifo_cnt=0, out_valid=0, issue_cnt=0, in_ready=1. A rise during flush still gives slow_tick=1 but issues nothing.

Source files
------------

// File: rtl/asl_slow_issue_bridge_pkg.sv
// Shared constants for the slow-issue bridge between the NICE producer
// and the PE array.
package asl_slow_issue_bridge_pkg;

  localparam int ASL_DW              = 32;
  localparam int ASL_BRIDGE_DEPTH    = 4;
  localparam int ASL_DIV_HALF_PERIOD = 8;
  localparam int ASL_ISSUE_CNT_W     = 16;
  localparam int ASL_AW              = $clog2(ASL_BRIDGE_DEPTH);

  typedef logic [ASL_DW-1:0]          asl_word_t;
  typedef logic [ASL_ISSUE_CNT_W-1:0] asl_issue_cnt_t;

endpackage

// File: rtl/asl_slow_issue_bridge_if.sv
// Producer-side handshake and PE-side issue bus of the slow-issue bridge.
// The producer drives in_*; the PE array observes out_*.
interface asl_slow_issue_bridge_if
  import asl_slow_issue_bridge_pkg::*;
#(
  parameter int DW = ASL_DW
) ();

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [DW-1:0] out_data;
  logic          out_valid;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_data,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_data,
    output out_valid
  );

endinterface

// File: rtl/asl_sync_fifo.sv
// Single-clock FIFO with synchronous clear; accepts no write while full,
// even when a read frees a slot in the same cycle.
module asl_sync_fifo
  import asl_slow_issue_bridge_pkg::*;
#(
  parameter int DW    = ASL_DW,
  parameter int DEPTH = ASL_BRIDGE_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          wr_valid_i,
  output logic          wr_ready_o,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_i,
  output logic [DW-1:0] rd_data_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full;
  logic          wr;
  logic          rd;

  assign full       = (count_q == FULL_CNT);
  assign empty_o    = (count_q == '0);
  assign wr_ready_o = ~full & ~clr_i;
  assign wr         = wr_valid_i & wr_ready_o;
  assign rd         = rd_i & ~empty_o & ~clr_i;
  assign rd_data_o  = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: a slot is only read after it was written.
  always_ff @(posedge clk_i) begin
    if (wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/asl_slow_issue_bridge.sv
// Rate-adapting issue stage: buffers producer words at clk_in rate and
// releases one word per rising edge of the divided clock level.
module asl_slow_issue_bridge
  import asl_slow_issue_bridge_pkg::*;
#(
  parameter int DW    = ASL_DW,
  parameter int DEPTH = ASL_BRIDGE_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                       clk_in,
  input  logic                       rst_n,
  input  logic                       div_clk,
  input  logic                       flush,
  asl_slow_issue_bridge_if.slave     bus,
  output logic                       slow_tick,
  output logic [AW:0]                fifo_cnt,
  output logic [ASL_ISSUE_CNT_W-1:0] issue_cnt
);

  logic                       div_q;
  logic                       rise;
  logic                       pop;
  logic                       fifo_empty;
  logic [DW-1:0]              fifo_rdata;
  logic [DW-1:0]              out_data_q, out_data_d;
  logic                       out_valid_q, out_valid_d;
  logic                       tick_q, tick_d;
  logic [ASL_ISSUE_CNT_W-1:0] issue_q, issue_d;

  // div_clk is a data level; div_q resets low so a first high is a rise.
  assign rise = div_clk & ~div_q;
  assign pop  = rise & ~fifo_empty & ~flush;

  asl_sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk_i      (clk_in),
    .rst_ni     (rst_n),
    .clr_i      (flush),
    .wr_valid_i (bus.in_valid),
    .wr_ready_o (bus.in_ready),
    .wr_data_i  (bus.in_data),
    .rd_i       (pop),
    .rd_data_o  (fifo_rdata),
    .empty_o    (fifo_empty),
    .count_o    (fifo_cnt)
  );

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    issue_d     = issue_q;
    tick_d      = rise;
    if (flush) begin
      out_valid_d = 1'b0;
      issue_d     = '0;
    end else if (rise) begin
      out_valid_d = pop;
      if (pop) begin
        out_data_d = fifo_rdata;
        issue_d    = issue_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      tick_q      <= 1'b0;
      issue_q     <= '0;
    end else begin
      div_q       <= div_clk;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      tick_q      <= tick_d;
      issue_q     <= issue_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign slow_tick     = tick_q;
  assign issue_cnt     = issue_q;

endmodule

// File: tb/tb_asl_slow_issue_bridge.sv
// Bench for asl_slow_issue_bridge: directed scenarios plus a random run,
// all checked against a queue-based model of the issue rules.
module tb_asl_slow_issue_bridge;
  import asl_slow_issue_bridge_pkg::*;

  localparam int DEPTH = ASL_BRIDGE_DEPTH;
  localparam int HP    = ASL_DIV_HALF_PERIOD;

  logic        clk_in  = 1'b0;
  logic        rst_n   = 1'b1;
  logic        div_clk = 1'b0;
  logic        flush   = 1'b0;
  logic        slow_tick;
  logic [2:0]  fifo_cnt;
  logic [15:0] issue_cnt;

  asl_slow_issue_bridge_if #(.DW(ASL_DW)) bus ();

  asl_slow_issue_bridge dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .div_clk   (div_clk),
    .flush     (flush),
    .bus       (bus),
    .slow_tick (slow_tick),
    .fifo_cnt  (fifo_cnt),
    .issue_cnt (issue_cnt)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;
  int divcnt;

  logic [31:0] mq [$];
  logic [31:0] m_data;
  logic [15:0] m_issue;
  bit          m_valid, m_tick, m_prev, m_ready;

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    flush   = 1'b0;
    div_clk = 1'b0;
    divcnt  = 0;
    #2 rst_n = 1'b0;
    @(posedge clk_in);
    #1 rst_n = 1'b1;
    mq.delete();
    m_data  = '0;
    m_issue = '0;
    m_valid = 0;
    m_tick  = 0;
    m_prev  = 0;
    m_ready = 1;
  endtask

  // One clk_in cycle: divider level, DUT edge and model update.
  task automatic cyc();
    bit rise, push;
    logic [31:0] d;
    div_clk = ((divcnt / HP) % 2) == 1;
    divcnt++;
    rise = div_clk && !m_prev;
    push = bus.in_valid && (mq.size() < DEPTH) && !flush;
    d = bus.in_data;
    @(posedge clk_in);
    #1;
    m_prev = div_clk;
    m_tick = rise;
    if (flush) begin
      mq.delete();
      m_valid = 0;
      m_issue = '0;
    end else begin
      if (rise) begin
        if (mq.size() > 0) begin
          m_data = mq.pop_front();
          m_valid = 1;
          m_issue++;
        end else begin
          m_valid = 0;
        end
      end
      if (push) mq.push_back(d);
    end
    m_ready = (mq.size() < DEPTH) && !flush;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.out_valid, slow_tick} !== 2'b00) begin
      bad++;
      $display("FAIL reset_flags got=%b want=00",
               {bus.out_valid, slow_tick});
    end
    total++;
    if (bus.out_data !== 32'h0 || issue_cnt !== 16'h0) begin
      bad++;
      $display("FAIL reset_regs data=%h issue=%0d want 0/0",
               bus.out_data, issue_cnt);
    end
    total++;
    if (fifo_cnt !== 3'd0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_fifo cnt=%0d rdy=%b want 0/1",
               fifo_cnt, bus.in_ready);
    end
    do_reset();
  endtask

  task automatic test_idle();
    int last, nt, gap_bad, flag_bad;
    do_reset();
    last = -1; nt = 0; gap_bad = 0; flag_bad = 0;
    for (int i = 0; i < 70; i++) begin
      cyc();
      if (slow_tick === 1'b1) begin
        if (last >= 0 && i - last != 2 * HP) gap_bad++;
        last = i;
        nt++;
      end
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
          issue_cnt !== 16'h0)
        flag_bad++;
    end
    total++;
    if (nt != 4 || gap_bad != 0) begin
      bad++;
      $display("FAIL idle_ticks count=%0d badgaps=%0d want 4/0",
               nt, gap_bad);
    end
    total++;
    if (flag_bad != 0) begin
      bad++;
      $display("FAIL idle_state badcycles=%0d want 0", flag_bad);
    end
  endtask

  task automatic test_single();
    int hold_bad;
    do_reset();
    hold_bad = 0;
    for (int i = 0; i < 25; i++) begin
      bus.in_valid = (i == 3);
      bus.in_data  = (i == 3) ? 32'hA5A5_0001 : 32'hDEAD_BEEF;
      cyc();
      if (i == 8) begin
        total++;
        if (bus.out_data !== 32'hA5A5_0001 || bus.out_valid !== 1'b1 ||
            slow_tick !== 1'b1) begin
          bad++;
          $display("FAIL single_issue data=%h v=%b t=%b want a5a50001/1/1",
                   bus.out_data, bus.out_valid, slow_tick);
        end
        total++;
        if (fifo_cnt !== 3'd0 || issue_cnt !== 16'd1) begin
          bad++;
          $display("FAIL single_cnt fifo=%0d issue=%0d want 0/1",
                   fifo_cnt, issue_cnt);
        end
      end
      if (i > 8 && bus.out_data !== 32'hA5A5_0001) hold_bad++;
    end
    bus.in_valid = 1'b0;
    total++;
    if (hold_bad != 0) begin
      bad++;
      $display("FAIL single_hold changed=%0d want 0", hold_bad);
    end
  endtask

  task automatic test_burst();
    int k, ord_bad;
    do_reset();
    k = 0; ord_bad = 0;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = (i < 6);
      bus.in_data  = 32'h10 + k;
      if (bus.in_valid && bus.in_ready) k++;
      cyc();
    end
    bus.in_valid = 1'b0;
    total++;
    if (k != 4 || fifo_cnt !== 3'd4 || bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL burst_full acc=%0d cnt=%0d rdy=%b want 4/4/0",
               k, fifo_cnt, bus.in_ready);
    end
    for (int i = 8; i < 60; i++) begin
      cyc();
      if (i == 8) begin
        total++;
        if (bus.out_data !== 32'h10 || bus.in_ready !== 1'b1 ||
            fifo_cnt !== 3'd3) begin
          bad++;
          $display("FAIL burst_first data=%h rdy=%b cnt=%0d want 10/1/3",
                   bus.out_data, bus.in_ready, fifo_cnt);
        end
      end
      if ((i - 8) % 16 == 0 &&
          bus.out_data !== 32'h10 + 32'((i - 8) / 16))
        ord_bad++;
    end
    total++;
    if (ord_bad != 0 || issue_cnt !== 16'd4) begin
      bad++;
      $display("FAIL burst_order bad=%0d issue=%0d want 0/4",
               ord_bad, issue_cnt);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    for (int i = 0; i < 41; i++) begin
      bus.in_valid = (i == 2) || (i == 8);
      bus.in_data  = (i == 2) ? 32'hC0DE_0000 : 32'hC0DE_0001;
      cyc();
      if (i == 8) begin
        total++;
        if (bus.out_data !== 32'hC0DE_0000 || fifo_cnt !== 3'd1) begin
          bad++;
          $display("FAIL same_old data=%h cnt=%0d want c0de0000/1",
                   bus.out_data, fifo_cnt);
        end
      end
      if (i == 24) begin
        total++;
        if (bus.out_data !== 32'hC0DE_0001 || fifo_cnt !== 3'd0) begin
          bad++;
          $display("FAIL same_new data=%h cnt=%0d want c0de0001/0",
                   bus.out_data, fifo_cnt);
        end
      end
      if (i == 40) begin
        total++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'hC0DE_0001 ||
            issue_cnt !== 16'd2 || slow_tick !== 1'b1) begin
          bad++;
          $display("FAIL underrun v=%b data=%h issue=%0d t=%b",
                   bus.out_valid, bus.out_data, issue_cnt, slow_tick);
        end
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i <= 72; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = $urandom;
      cyc();
    end
    bus.in_valid = 1'b0;
    total++;
    if (fifo_cnt !== 3'd3 || issue_cnt !== 16'd5) begin
      bad++;
      $display("FAIL flush_pre cnt=%0d issue=%0d want 3/5",
               fifo_cnt, issue_cnt);
    end
    flush = 1'b1;
    cyc();
    total++;
    if (fifo_cnt !== 3'd0 || bus.out_valid !== 1'b0 ||
        issue_cnt !== 16'd0) begin
      bad++;
      $display("FAIL flush_clear cnt=%0d v=%b issue=%0d want 0/0/0",
               fifo_cnt, bus.out_valid, issue_cnt);
    end
    flush = 1'b0;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush_ready got=%b want 1", bus.in_ready);
    end
    flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h5555_AAAA;
    for (int i = 74; i <= 88; i++) cyc();
    total++;
    if (slow_tick !== 1'b1 || bus.out_valid !== 1'b0 ||
        issue_cnt !== 16'd0 || fifo_cnt !== 3'd0 ||
        bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL flush_tick t=%b v=%b issue=%0d cnt=%0d rdy=%b",
               slow_tick, bus.out_valid, issue_cnt, fifo_cnt,
               bus.in_ready);
    end
    flush = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_random();
    int errs;
    do_reset();
    errs = 0;
    for (int i = 0; i < 1200; i++) begin
      bus.in_valid = (i < 600) ? ($urandom_range(0, 9) == 0)
                               : ($urandom_range(0, 3) != 0);
      bus.in_data  = $urandom;
      flush        = ($urandom_range(0, 63) == 0);
      cyc();
      total++;
      if (bus.out_valid !== m_valid || slow_tick !== m_tick ||
          fifo_cnt !== 3'(mq.size()) || issue_cnt !== m_issue ||
          bus.in_ready !== m_ready ||
          (m_valid && bus.out_data !== m_data)) begin
        bad++;
        errs++;
        if (errs < 6)
          $display("FAIL rand_c%0d v=%b/%b t=%b/%b cnt=%0d/%0d is=%0d/%0d d=%h/%h",
                   i, bus.out_valid, m_valid, slow_tick, m_tick,
                   fifo_cnt, mq.size(), issue_cnt, m_issue,
                   bus.out_data, m_data);
      end
    end
    flush = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    total++;
    if (fifo_cnt !== 3'd0 || bus.out_valid !== 1'b0 ||
        issue_cnt !== 16'd0 || slow_tick !== 1'b0) begin
      bad++;
      $display("FAIL async_reset cnt=%0d v=%b issue=%0d t=%b",
               fifo_cnt, bus.out_valid, issue_cnt, slow_tick);
    end
    do_reset();
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    test_reset();
    test_idle();
    test_single();
    test_burst();
    test_same_cycle();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
